// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared state encoding and sizing helper for the UART TX arbiter
//
// Purpose: holds the arbiter FSM state constants and the ceiling-log2 helper
// used to size the requester index and the burst counter.
// Ports:   none (package).

package uart_tx_arbiter_pkg;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StHeader = 2'd1;
    localparam logic [1:0] StData   = 2'd2;

    // Smallest r with (1 << r) >= value; used only on elaboration constants.
    function automatic int log2Ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick of one request
//
// Purpose: selects the first set bit of ReqVec searching upward from Ptr+1,
//          wrapping past the top, so the previous winner has lowest priority.
// Ports:   ReqVec    - request vector, one bit per requester
//          Ptr       - index of the previous winner
//          SelOneHot - one-hot winner (all zero when nothing requested)
//          SelIdx    - index of the winner
//          SelValid  - at least one request was present

module rr_priority_pick #(
    parameter int NumReq  = 4,
    parameter int IdWidth = 2
) (
    input  logic [NumReq-1:0]  ReqVec,
    input  logic [IdWidth-1:0] Ptr,
    output logic [NumReq-1:0]  SelOneHot,
    output logic [IdWidth-1:0] SelIdx,
    output logic               SelValid
);

    int idx;

    always_comb begin
        SelOneHot = '0;
        SelIdx    = '0;
        SelValid  = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NumReq; i++) begin
            idx = int'(Ptr) + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (!SelValid && ReqVec[idx]) begin
                SelValid       = 1'b1;
                SelOneHot[idx] = 1'b1;
                SelIdx         = IdWidth'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - burst-locked round-robin arbiter in front of a UART TX byte port
//
// Purpose: shares one transmitter byte port between NumReq byte streams. A
//          winner keeps the port until its last byte or MaxBurst data bytes,
//          optionally preceded by a header byte naming the requester.
// Ports:   Clock, Reset (async, active low)
//          ReqData/ReqValid/ReqLast/ReqReady - requester byte streams
//          TxData/TxValid/TxReady            - transmitter byte port
//          Grant - registered one-hot owner, Busy - not idle

module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int         NumReq       = 4,
    parameter int         IdWidth      = log2Ceil(NumReq),
    parameter int         MaxBurst     = 16,
    parameter bit         InsertHeader = 1'b1,
    parameter logic [7:0] HeaderBase   = 8'hA0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [NumReq*8-1:0] ReqData,
    input  logic [NumReq-1:0]   ReqValid,
    input  logic [NumReq-1:0]   ReqLast,
    output logic [NumReq-1:0]   ReqReady,
    output logic [7:0]          TxData,
    output logic                TxValid,
    input  logic                TxReady,
    output logic [NumReq-1:0]   Grant,
    output logic                Busy
);

    localparam int CntWidth = log2Ceil(MaxBurst + 1);

    logic [1:0]          state;
    logic [NumReq-1:0]   grantReg;
    logic [IdWidth-1:0]  grantId;
    logic [IdWidth-1:0]  ptr;
    logic [CntWidth-1:0] burstCnt;

    logic [NumReq-1:0]   selOneHot;
    logic [IdWidth-1:0]  selIdx;
    logic                selValid;
    logic [7:0]          grantData;
    logic                txFire;
    logic                burstEnd;

    rr_priority_pick #(
        .NumReq  (NumReq),
        .IdWidth (IdWidth)
    ) u_pick (
        .ReqVec    (ReqValid),
        .Ptr       (ptr),
        .SelOneHot (selOneHot),
        .SelIdx    (selIdx),
        .SelValid  (selValid)
    );

    assign grantData = ReqData[{grantId, 3'b000} +: 8];
    assign txFire    = TxValid && TxReady;
    // Release on the marked last byte or when this byte fills the burst quota.
    assign burstEnd  = ReqLast[grantId] || (burstCnt == CntWidth'(MaxBurst - 1));

    assign Grant = grantReg;
    assign Busy  = (state != StIdle);

    // Output side: the granted requester is passed straight through in DATA.
    always_comb begin
        TxValid  = 1'b0;
        TxData   = 8'h00;
        ReqReady = '0;
        case (state)
            StHeader: begin
                TxValid = 1'b1;
                TxData  = HeaderBase | {{(8 - IdWidth){1'b0}}, grantId};
            end
            StData: begin
                TxValid           = ReqValid[grantId];
                TxData            = grantData;
                ReqReady[grantId] = TxReady;
            end
            default: begin
                TxValid  = 1'b0;
                TxData   = 8'h00;
                ReqReady = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= StIdle;
            grantReg <= '0;
            grantId  <= '0;
            ptr      <= IdWidth'(NumReq - 1);
            burstCnt <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (selValid) begin
                        grantReg <= selOneHot;
                        grantId  <= selIdx;
                        burstCnt <= '0;
                        state    <= InsertHeader ? StHeader : StData;
                    end
                end
                StHeader: begin
                    if (txFire) begin
                        state <= StData;
                    end
                end
                StData: begin
                    if (txFire) begin
                        burstCnt <= burstCnt + CntWidth'(1);
                        if (burstEnd) begin
                            state    <= StIdle;
                            ptr      <= grantId;
                            grantReg <= '0;
                        end
                    end
                end
                default: begin
                    state    <= StIdle;
                    grantReg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

    localparam int NumReq   = 4;
    localparam int MaxBurst = 16;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] ReqData;
    logic [3:0]  ReqValid, ReqLast, ReqReady, Grant;
    logic [7:0]  TxData;
    logic        TxValid, TxReady, Busy;

    logic [31:0] ReqDataNh;
    logic [3:0]  ReqValidNh, ReqLastNh, ReqReadyNh, GrantNh;
    logic [7:0]  TxDataNh;
    logic        TxValidNh, TxReadyNh, BusyNh;

    always #5 Clock = ~Clock;

    uart_tx_arbiter #(.NumReq(NumReq), .MaxBurst(MaxBurst), .InsertHeader(1'b1), .HeaderBase(8'hA0)) dut (
        .Clock(Clock), .Reset(Reset), .ReqData(ReqData), .ReqValid(ReqValid), .ReqLast(ReqLast),
        .ReqReady(ReqReady), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .Grant(Grant), .Busy(Busy));

    uart_tx_arbiter #(.NumReq(NumReq), .MaxBurst(MaxBurst), .InsertHeader(1'b0), .HeaderBase(8'hA0)) dutNh (
        .Clock(Clock), .Reset(Reset), .ReqData(ReqDataNh), .ReqValid(ReqValidNh), .ReqLast(ReqLastNh),
        .ReqReady(ReqReadyNh), .TxData(TxDataNh), .TxValid(TxValidNh), .TxReady(TxReadyNh),
        .Grant(GrantNh), .Busy(BusyNh));

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        txReady;
        logic [3:0]  expGrant;
        logic        expTxValid;
        logic [7:0]  expTxData;
        logic        expBusy;
        logic [3:0]  expReqReady;
    } VecT;

    VecT tbl [10];

    int checks = 0;
    int errors = 0;

    logic [8:0] srcQ [NumReq][$];
    logic [8:0] modelQ [NumReq][$];
    logic [7:0] expQ [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic doReset();
        Reset = 1'b0;
        ReqValid = '0; ReqLast = '0; ReqData = '0; TxReady = 1'b0;
        ReqValidNh = '0; ReqLastNh = '0; ReqDataNh = '0; TxReadyNh = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    // Transaction-level reference: whole bursts chosen from queue occupancy.
    task automatic buildExpected();
        int ptr;
        int idx;
        int cnt;
        logic [8:0] e;
        bit done;
        ptr = NumReq - 1;
        expQ.delete();
        for (int i = 0; i < NumReq; i++) modelQ[i] = srcQ[i];
        while (1) begin
            idx = -1;
            for (int k = 1; k <= NumReq; k++) begin
                if (idx < 0 && modelQ[(ptr + k) % NumReq].size() > 0) idx = (ptr + k) % NumReq;
            end
            if (idx < 0) break;
            expQ.push_back(8'hA0 | 8'(idx));
            cnt = 0;
            done = 1'b0;
            while (!done) begin
                e = modelQ[idx].pop_front();
                expQ.push_back(e[7:0]);
                cnt++;
                done = e[8] || (cnt == MaxBurst) || (modelQ[idx].size() == 0);
            end
            ptr = idx;
        end
    endtask

    // Drives the source queues with random backpressure and valid gaps and
    // compares every transmitted byte with the reference stream.
    task automatic runStream(input string name, input int budget);
        buildExpected();
        for (int cyc = 0; cyc < budget && expQ.size() > 0; cyc++) begin
            @(posedge Clock);
            #1;
            for (int i = 0; i < NumReq; i++) begin
                if (srcQ[i].size() > 0) begin
                    ReqValid[i]       = !(Grant[i] && $urandom_range(0, 4) == 0);
                    ReqData[i*8 +: 8] = srcQ[i][0][7:0];
                    ReqLast[i]        = srcQ[i][0][8];
                end else begin
                    ReqValid[i]       = 1'b0;
                    ReqData[i*8 +: 8] = 8'($urandom);
                    ReqLast[i]        = 1'($urandom);
                end
            end
            TxReady = ($urandom_range(0, 3) != 0);
            @(negedge Clock);
            check({name, "_rr_granted_only"}, 32'(ReqReady & ~Grant), 0);
            check({name, "_rr_mirrors_txready"}, 32'(ReqReady & ~{4{TxReady}}), 0);
            if (TxValid && TxReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra_byte actual=%0h required=none", name, TxData);
                end else begin
                    if (TxData !== expQ[0]) begin
                        errors++;
                        $display("FAIL %s_byte actual=%0h required=%0h", name, TxData, expQ[0]);
                    end
                    void'(expQ.pop_front());
                end
            end
            for (int i = 0; i < NumReq; i++) begin
                if (ReqValid[i] && ReqReady[i]) void'(srcQ[i].pop_front());
            end
        end
        check({name, "_bytes_left"}, 32'(expQ.size()), 0);
        @(posedge Clock);
        #1;
        ReqValid = '0;
        repeat (2) @(negedge Clock);
        check({name, "_idle_after"}, 32'(Busy), 0);
    endtask

    task automatic genRandom();
        int np;
        int len;
        for (int i = 0; i < NumReq; i++) begin
            srcQ[i].delete();
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) begin
                len = $urandom_range(1, 24);
                for (int b = 0; b < len; b++) srcQ[i].push_back({(b == len - 1), 8'($urandom)});
            end
        end
    endtask

    initial begin
        int got;
        int id;

        //              valid    data          last     rdy   grant    tv    td     busy  rready
        tbl[0] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000};
        tbl[1] = '{4'b0100, 32'h00110000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000};
        tbl[2] = '{4'b0100, 32'h00110000, 4'b0000, 1'b0, 4'b0100, 1'b1, 8'hA2, 1'b1, 4'b0000};
        tbl[3] = '{4'b0100, 32'h00110000, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'hA2, 1'b1, 4'b0000};
        tbl[4] = '{4'b0101, 32'h001100EE, 4'b0001, 1'b0, 4'b0100, 1'b1, 8'h11, 1'b1, 4'b0000};
        tbl[5] = '{4'b0100, 32'h00110000, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'h11, 1'b1, 4'b0100};
        tbl[6] = '{4'b0000, 32'h00220000, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'h22, 1'b1, 4'b0100};
        tbl[7] = '{4'b0100, 32'h00220000, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'h22, 1'b1, 4'b0100};
        tbl[8] = '{4'b0100, 32'h00330000, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h33, 1'b1, 4'b0100};
        tbl[9] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000};

        Reset = 1'b0;
        ReqValid = '0; ReqLast = '0; ReqData = '0; TxReady = 1'b0;
        ReqValidNh = '0; ReqLastNh = '0; ReqDataNh = '0; TxReadyNh = 1'b0;

        // Reset in the middle of a burst, then round robin from requester 0.
        doReset();
        @(posedge Clock);
        #1;
        ReqValid = 4'b1111; ReqLast = 4'b1111; ReqData = 32'h13121110; TxReady = 1'b0;
        @(posedge Clock);
        #1;
        @(negedge Clock);
        check("t1_busy_before_reset", 32'(Busy), 1);
        #2;
        Reset = 1'b0;
        #1;
        check("t1_reset_grant", 32'(Grant), 0);
        check("t1_reset_txvalid", 32'(TxValid), 0);
        check("t1_reset_busy", 32'(Busy), 0);
        check("t1_reset_reqready", 32'(ReqReady), 0);
        check("t1_reset_txdata", 32'(TxData), 0);
        @(negedge Clock);
        Reset = 1'b1;
        TxReady = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 100 && got < 12; cyc++) begin
            @(negedge Clock);
            if (TxValid && TxReady) begin
                id = (got / 2) % 4;
                check("t3_rr_grant", 32'(Grant), 32'(1 << id));
                check("t3_rr_byte", 32'(TxData), (got % 2 == 0) ? 32'(8'hA0 | 8'(id)) : 32'(8'h10 + 8'(id)));
                got++;
            end
        end
        check("t3_rr_count", got, 12);

        // Single burst with header stall, data stall, valid gap and a foreign request.
        doReset();
        for (int r = 0; r < 10; r++) begin
            @(posedge Clock);
            #1;
            ReqValid = tbl[r].valid;
            ReqData  = tbl[r].data;
            ReqLast  = tbl[r].last;
            TxReady  = tbl[r].txReady;
            @(negedge Clock);
            check($sformatf("vec%0d_grant", r), 32'(Grant), 32'(tbl[r].expGrant));
            check($sformatf("vec%0d_txvalid", r), 32'(TxValid), 32'(tbl[r].expTxValid));
            if (tbl[r].expTxValid) check($sformatf("vec%0d_txdata", r), 32'(TxData), 32'(tbl[r].expTxData));
            check($sformatf("vec%0d_busy", r), 32'(Busy), 32'(tbl[r].expBusy));
            check($sformatf("vec%0d_reqready", r), 32'(ReqReady), 32'(tbl[r].expReqReady));
        end

        // Forced release at MaxBurst with another requester waiting.
        doReset();
        for (int i = 0; i < NumReq; i++) srcQ[i].delete();
        for (int b = 1; b <= 20; b++) srcQ[1].push_back({(b == 20), 8'(b)});
        srcQ[3].push_back({1'b1, 8'hC3});
        runStream("t4_maxburst", 2000);

        // Randomized streams against the reference model.
        for (int round = 0; round < 4; round++) begin
            doReset();
            genRandom();
            runStream($sformatf("rand%0d", round), 3000);
        end

        // No-header instance: first data byte one cycle after the request.
        @(posedge Clock);
        #1;
        ReqValidNh = 4'b0001; ReqDataNh = 32'h00000055; ReqLastNh = 4'b0001; TxReadyNh = 1'b1;
        @(negedge Clock);
        check("t6_idle_txvalid", 32'(TxValidNh), 0);
        @(posedge Clock);
        #1;
        @(negedge Clock);
        check("t6_txvalid", 32'(TxValidNh), 1);
        check("t6_txdata", 32'(TxDataNh), 32'h55);
        check("t6_grant", 32'(GrantNh), 32'h1);
        check("t6_reqready", 32'(ReqReadyNh), 32'h1);
        @(posedge Clock);
        #1;
        ReqValidNh = '0;
        @(negedge Clock);
        check("t6_after_txvalid", 32'(TxValidNh), 0);
        check("t6_after_busy", 32'(BusyNh), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter byte port (8-bit valid/ready, DataIn/DataInValid/DataInReady) between NumReq byte-stream requesters.
- Grants are burst-locked: a requester holds the transmitter until it marks its last byte, or until MaxBurst bytes have been sent.
- Optionally prefixes each burst with a header byte that identifies the requester, so the host can demultiplex the serial stream.
- Sits between on-chip clients (debug console, status reporter, bootloader echo) and the transmitter.

Parameters:
NumReq, 4, number of requesters (2..8).
IdWidth, log2(NumReq), width of the requester index.
MaxBurst, 16, maximum data bytes per grant before the grant is forcibly released (1..255).
InsertHeader, 1, 1 = send header byte before each burst; 0 = no header.
HeaderBase, 8'hA0, header byte = HeaderBase OR zero-extended requester index.

Ports:
Clock  input  1  system clock, all state on rising edge.
Reset  input  1  asynchronous, active-low reset.
ReqData  input  NumReq*8  requester i byte at bits [8i+7:8i].
ReqValid  input  NumReq  requester i has a byte.
ReqLast  input  NumReq  requester i byte is the final byte of its burst.
ReqReady  output  NumReq  byte of requester i accepted this cycle.
TxData  output  8  byte to transmitter DataIn.
TxValid  output  1  to transmitter DataInValid.
TxReady  input  1  from transmitter DataInReady.
Grant  output  NumReq  one-hot registered grant; all-zero when idle.
Busy  output  1  high in any state other than IDLE.

Behaviour:
- A transfer occurs when TxValid && TxReady are both high in the same cycle. Upstream, requester i transfers when ReqValid[i] && ReqReady[i].
- States:
  - IDLE: Grant=0, TxValid=0, ReqReady=0.
    - If any ReqValid bit is high, select the first set bit searching from Ptr+1 upward with wrap.
    - Next cycle: Grant=onehot(sel), GrantId=sel, BurstCnt=0. Go to HEADER if InsertHeader, else DATA.
  - HEADER: TxValid=1, TxData=HeaderBase|GrantId, ReqReady=0. On transfer, go to DATA.
  - DATA: TxValid=ReqValid[g], TxData=ReqData[g], ReqReady[g]=TxReady, all other ReqReady=0 (combinational pass-through).
    - On each transfer, BurstCnt increments.
    - If the transferred byte has ReqLast[g]=1, or BurstCnt==MaxBurst-1, go to IDLE: Ptr<=g, Grant<=0.
- Latency: ReqValid rising in IDLE produces TxValid high on the next cycle (header byte, or first data byte when InsertHeader=0). There is at least one IDLE cycle between bursts.
- Requests that arrive while not in IDLE are ignored until the next IDLE evaluation. Request lines are sampled only in IDLE.
- If the granted requester drops ReqValid mid-burst, stay in DATA with TxValid=0. There is no timeout; the grant is held.
- A forced release at MaxBurst is not signalled to the requester. Its remaining bytes go out in a later grant, with a fresh header.
- A non-granted requester never sees ReqReady=1.
- ReqValid/ReqData/ReqLast changes on a non-granted requester have no effect.
- BurstCnt is ceil(log2(MaxBurst+1)) bits wide and never wraps; release happens first.
- Reset (asynchronous, Reset=0): state=IDLE, Grant=0, Busy=0, TxValid=0, ReqReady=0, TxData=0, BurstCnt=0, Ptr=NumReq-1, so requester 0 wins first.
- Reset asserted mid-burst aborts immediately; the partial byte stream is not completed.
- Busy=1 in HEADER and DATA.

Decomposition:
- Shared package/header: state encoding localparams (IDLE, HEADER, DATA) and the log2 function (util.vh).
- One sub-module, rr_priority_pick: combinational, takes the request vector and Ptr, returns one-hot select and index. It is reusable for other shared resources.
- The FSM, counters and mux stay in uart_tx_arbiter.

Test Plan:
1. Reset state: Reset low mid-operation with requests pending -> Grant=0, TxValid=0, Busy=0 immediately; after release, the first grant goes to requester 0 when all ReqValid=4'b1111.
2. Single burst: requester 2 sends 3 bytes 8'h11, 8'h22, 8'h33 (last) with TxReady=1 -> TxData sequence 8'hA2, 8'h11, 8'h22, 8'h33; TxValid first high one cycle after ReqValid; Grant=4'b0100 throughout, then 0.
3. Round robin: all four requesters hold 1-byte bursts continuously -> grant order 0,1,2,3,0,1; each header equals A0|id.
4. MaxBurst: requester 1 sends 20 bytes, last on byte 20, MaxBurst=16 -> 16 data bytes, then IDLE. Requester 3 is also pending and is granted next. Requester 1 later resumes with header 8'hA1 and its 4 remaining bytes.
5. Backpressure and stall: TxReady low for 10 cycles during HEADER and during DATA, and granted ReqValid dropped for 5 cycles -> no byte lost or duplicated, ReqReady[g] mirrors TxReady only, no other requester gets ReqReady.
6. InsertHeader=0: requester 0 sends 8'h55 (last) -> TxData=8'h55 one cycle after ReqValid, no header byte emitted.
